// File: rtl/button_conditioner.sv
// Pushbutton conditioner: two-flop synchronizer, stability-counter debouncer
// FSM, registered press/release strobes and a once-per-press long-press strobe.
module button_conditioner #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int LONG_CYCLES   = 100000000,
    parameter int CNT_W         = 27
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic db_level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        WAIT_HIGH = 2'd1,
        HIGH      = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    logic             sync1;
    logic             sync_q;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_next;
    logic             db_next;
    logic             rise_next;
    logic             fall_next;
    logic             enter_high;

    // Bring the asynchronous pin into the clk domain; only sync_q is used.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync1  <= button;
            sync_q <= sync1;
        end
    end

    // Debounce FSM next state, stability count and strobe decisions.
    always_comb begin
        state_next = state;
        stab_next  = stab_cnt;
        db_next    = db_level;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        enter_high = 1'b0;
        case (state)
            LOW: begin
                if (sync_q) begin
                    state_next = WAIT_HIGH;
                    stab_next  = CNT_ONE;
                end else begin
                    stab_next  = CNT_ZERO;
                end
            end
            WAIT_HIGH: begin
                if (!sync_q) begin
                    // Bounce: drop back and restart the count from scratch.
                    state_next = LOW;
                    stab_next  = CNT_ZERO;
                end else if (stab_cnt == STAB_LAST) begin
                    state_next = HIGH;
                    stab_next  = CNT_ZERO;
                    db_next    = 1'b1;
                    rise_next  = 1'b1;
                    enter_high = 1'b1;
                end else begin
                    stab_next  = stab_cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!sync_q) begin
                    state_next = WAIT_LOW;
                    stab_next  = CNT_ONE;
                end else begin
                    stab_next  = CNT_ZERO;
                end
            end
            WAIT_LOW: begin
                if (sync_q) begin
                    // Release glitch: back to HIGH with no strobe.
                    state_next = HIGH;
                    stab_next  = CNT_ZERO;
                end else if (stab_cnt == STAB_LAST) begin
                    state_next = LOW;
                    stab_next  = CNT_ZERO;
                    db_next    = 1'b0;
                    fall_next  = 1'b1;
                end else begin
                    stab_next  = stab_cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = LOW;
                stab_next  = CNT_ZERO;
                db_next    = 1'b0;
            end
        endcase
    end

    // FSM state, counter and registered level/strobe outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= LOW;
            stab_cnt <= CNT_ZERO;
            db_level <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            state    <= state_next;
            stab_cnt <= stab_next;
            db_level <= db_next;
            rise     <= rise_next;
            fall     <= fall_next;
        end
    end

    generate
        if (LONG_CYCLES == 0) begin : g_no_long
            // Long-press detection disabled: strobe held low.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    long_press <= 1'b0;
                end else begin
                    long_press <= 1'b0;
                end
            end
        end else begin : g_long
            localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
            localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

            logic [CNT_W-1:0] hold_cnt;
            logic             long_done;
            logic             fire;

            // Fire once per press when the hold count reaches its last value.
            always_comb begin
                if (db_level && !long_done && (hold_cnt == LONG_LAST)) begin
                    fire = 1'b1;
                end else begin
                    fire = 1'b0;
                end
            end

            // Hold counter (cleared on accepted press, keeps running through
            // WAIT_LOW, saturates) and the one-shot long-press strobe.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    hold_cnt   <= CNT_ZERO;
                    long_done  <= 1'b0;
                    long_press <= 1'b0;
                end else begin
                    long_press <= fire;
                    if (enter_high) begin
                        hold_cnt <= CNT_ZERO;
                    end else if (db_level && (hold_cnt < LONG_MAX)) begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                    end else begin
                        hold_cnt <= hold_cnt;
                    end
                    if (!db_level) begin
                        long_done <= 1'b0;
                    end else if (fire) begin
                        long_done <= 1'b1;
                    end else begin
                        long_done <= long_done;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with STABLE_CYCLES=4, LONG_CYCLES=10.
module tb_button_conditioner;

    logic clk;
    logic reset;
    logic button;
    logic db_level;
    logic rise;
    logic fall;
    logic long_press;

    int total_cnt;
    int pass_cnt;

    typedef struct {
        logic rst;
        logic btn;
        logic db;
        logic ri;
        logic fa;
        logic lp;
    } vec_t;

    vec_t vecs[$];

    button_conditioner #(
        .STABLE_CYCLES(4),
        .LONG_CYCLES  (10),
        .CNT_W        (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button    (button),
        .db_level  (db_level),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void add_run(input int n, input logic rst, input logic btn,
                                    input logic db, input logic ri, input logic fa,
                                    input logic lp);
        vec_t v;
        v.rst = rst; v.btn = btn; v.db = db; v.ri = ri; v.fa = fa; v.lp = lp;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // Drive inputs, take one rising edge, sample outputs 1 time unit later.
    task automatic tick(input logic rst, input logic btn);
        reset  = rst;
        button = btn;
        @(posedge clk);
        #1;
    endtask

    // Button follows pat[i-1] on tick i; each strobe is expected only on its tick (0 = never).
    task automatic run_pattern(input int n, input logic [63:0] pat, input int rise_at,
                               input int fall_at, input int long_at, input string tag);
        for (int i = 1; i <= n; i++) begin
            tick(1'b1, pat[i-1]);
            check({tag, " rise"}, rise, (i == rise_at) ? 1'b1 : 1'b0);
            check({tag, " fall"}, fall, (i == fall_at) ? 1'b1 : 1'b0);
            check({tag, " long_press"}, long_press, (i == long_at) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        reset     = 1'b0;
        button    = 1'b0;

        // rst, btn -> db, rise, fall, long
        add_run(3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // reset held, pin high
        add_run(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // released, still settling
        add_run(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); // rise 6 edges after release
        add_run(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_run(5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // release
        add_run(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); // fall
        add_run(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_run(5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // clean press
        add_run(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_run(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_run(5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); // clean release
        add_run(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_run(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_run(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // bounce: 1 x3
        add_run(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); //         0 x2
        add_run(3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); //         1 x3
        add_run(8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); //         then 0

        foreach (vecs[k]) begin
            tick(vecs[k].rst, vecs[k].btn);
            check($sformatf("vec%0d db_level", k), db_level, vecs[k].db);
            check($sformatf("vec%0d rise", k), rise, vecs[k].ri);
            check($sformatf("vec%0d fall", k), fall, vecs[k].fa);
            check($sformatf("vec%0d long_press", k), long_press, vecs[k].lp);
        end

        // Release with a glitch back to 1: one fall 6 edges after the last 1->0.
        run_pattern(20, {64{1'b1}}, 6, 0, 16, "press_a");
        run_pattern(12, 64'h0000_0000_0000_000C, 0, 10, 0, "rel_bounce");
        check("rel_bounce db_level", db_level, 1'b0);

        // Long press twice: long_press once per press, 10 cycles after rise.
        run_pattern(30, {64{1'b1}}, 6, 0, 16, "long_1");
        check("long_1 db_level", db_level, 1'b1);
        run_pattern(8, 64'd0, 0, 6, 0, "rel_1");
        run_pattern(30, {64{1'b1}}, 6, 0, 16, "long_2");
        run_pattern(8, 64'd0, 0, 6, 0, "rel_2");
        check("rel_2 db_level", db_level, 1'b0);

        // Reset two cycles after rise while the pin is still held.
        run_pattern(8, {64{1'b1}}, 6, 0, 0, "press_r");
        tick(1'b0, 1'b1);
        check("midrst db_level", db_level, 1'b0);
        check("midrst rise", rise, 1'b0);
        check("midrst fall", fall, 1'b0);
        check("midrst long_press", long_press, 1'b0);
        run_pattern(20, {64{1'b1}}, 6, 0, 16, "after_rst");
        run_pattern(8, 64'd0, 0, 6, 0, "rel_r");
        check("rel_r db_level", db_level, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
